spi_read_buffer: RTL and testbench
==================================

// Module: spi_read_buffer
// PURPOSE
//  First-word-fall-through FIFO between the DMA AXI-Stream source and the SPI loader.
//  Accepts 32-bit program words plus the tlast flag on a slave AXI-Stream port.
//  Presents the head word and its last flag to the loader; the loader's rb_ready pulse pops it.
//  Raises primed once enough words are buffered for the loader to stream without starving.
// PARAMETERS
//  DATA_W   32  word width, which must equal the loader's spi_data width
//  DEPTH    16  FIFO entries; must be a power of two and >= 2
//  PREFILL  8   words buffered before primed asserts (1..DEPTH)
//  CNT_W    16  width of the popped-word counter
// PORTS
//  clk            in   1        single clock; all logic on posedge
//  rst            in   1        synchronous, active-high reset
//  clear          in   1        synchronous soft clear; same effect as rst
//  s_axis_tdata   in   DATA_W   incoming word
//  s_axis_tvalid  in   1        incoming word valid
//  s_axis_tlast   in   1        marks the final program word
//  s_axis_tready  out  1        FIFO can accept a word
//  spi_data       out  DATA_W   head word (feeds loader spi_data)
//  last_o         out  1        head word carries tlast (feeds loader last_i)
//  rb_ready       in   1        one-cycle pop strobe from loader
//  primed         out  1        buffer ready for loader streaming
//  level          out  $clog2(DEPTH)+1  current occupancy
//  words_popped   out  CNT_W    number of words consumed by the loader
//  underflow      out  1        sticky: pop seen while empty
//  done           out  1        word with tlast has been popped
// BEHAVIOUR
//  - Reset/clear values:
//    - pointers=0, level=0, state=IDLE.
//    - all outputs 0, except s_axis_tready=1.
//  - Storage is DATA_W+1 bits per entry (word + last flag).
//  - spi_data and last_o come combinationally from mem[rd_ptr].
//    - Both read 0 when the FIFO is empty.
//  - Push occurs when s_axis_tvalid && s_axis_tready; the entry is visible at the head next cycle.
//  - Pop occurs when rb_ready && level!=0.
//    - rd_ptr advances and words_popped increments; the counter wraps at 2^CNT_W.
//  - rb_ready while empty: no pop and no pointer change; underflow sets and stays set until rst/clear.
//  - Push and pop in the same cycle leave level unchanged; legal at any level, including full.
//  - Pointers wrap modulo DEPTH; level saturates neither up nor down by construction.
//  - s_axis_tready = (level<DEPTH || pop) && state in {IDLE,FILL,STREAM}.
//  - FSM:
//    - IDLE: empty. A push goes to FILL.
//    - FILL: primed=0. Go to STREAM when (level after update) >= PREFILL, or when a tlast word is pushed.
//    - STREAM: primed=1. Accepting a tlast word goes to DRAIN.
//    - DRAIN: primed=1, tready=0. Popping the head word with last=1 goes to DONE.
//    - DONE: done=1, primed=0, tready=0. Only rst/clear leaves DONE.
//  - Once set, primed stays 1 in STREAM even if level falls to 0; the source is responsible for keeping up.
//  - A second tlast cannot be accepted, because tready drops after the first.
//  - Reset or clear mid-stream discards all contents the same cycle; in-flight words are lost.
// STRUCTURE
//  - Shared package spi_load_pkg: DATA_W default, FSM state encoding (3-bit localparams), CNT_W.
//  - One sub-module sync_fifo_fwft (mem, pointers, level, push/pop); FSM and flags stay at top.
//  - Expected size: roughly 150-250 lines total.
// TESTING
//  1 - Reset: after rst held 1 cycle, s_axis_tready=1, level=0, primed=0, spi_data=0, done=0.
//  2 - Prime: push 8 words 0xA0..0xA7 with PREFILL=8; primed rises the cycle after the 8th push, and spi_data=0xA0.
//  3 - Full: push 16 words with no pops; s_axis_tready=0 at level 16.
//    - Pop and push in the same cycle; level stays 16 and the new word lands at the tail.
//  4 - Last: push 3 words, the third with tlast; state reaches STREAM with level=3.
//    - Pop 3 times; last_o=1 on the 3rd head, done=1 afterwards, and words_popped=3.
//  5 - Underflow: pulse rb_ready on an empty FIFO; underflow=1, level stays 0, and words_popped stays 0.
//  6 - Clear: assert clear with 5 words buffered in STREAM; the next cycle shows level=0, state=IDLE, and primed=0.

Source files
------------

// File: rtl/spi_load_pkg.sv
// Shared definitions for the SPI program-load path.
//  - Default data and counter widths.
//  - 3-bit state encoding for the read-buffer FSM, kept as plain localparams so
//    older tooling and waveform decoders see stable numeric values.
//  - Helper that says whether a state may accept a new word from the stream.
package spi_load_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic state_accepts(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_FILL) || (st == ST_STREAM);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//  clk    : clock, all state on posedge
//  flush  : synchronous flush (pointers and level to 0)
//  push   : write wdata at the tail (caller guarantees space or a same-cycle pop)
//  wdata  : entry to write
//  pop    : drop the head entry (caller guarantees level != 0)
//  rdata  : head entry, combinational; reads 0 while empty
//  level  : current occupancy, 0..DEPTH
module sync_fifo_fwft
    import spi_load_pkg::*;
#(
    parameter int W     = DATA_W_DEF + 1,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Contents need no reset: the head is masked to 0 whenever level is 0.
    // When full, push and pop target the same slot; the head is read
    // combinationally before the edge, so the old word leaves as the new
    // one becomes the tail.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = (level == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spi_read_buffer.sv
// Read buffer between the DMA AXI-Stream source and the SPI loader.
//  clk, rst, clear      : clock, sync active-high reset, sync soft clear (same effect)
//  s_axis_tdata/tvalid/tlast/tready : slave AXI-Stream input of program words
//  spi_data, last_o     : head word and its last flag, combinational, 0 when empty
//  rb_ready             : one-cycle pop strobe from the loader
//  primed               : enough words buffered for the loader to stream
//  level                : current occupancy
//  words_popped         : words consumed by the loader (wraps)
//  underflow            : sticky, pop strobe seen while empty
//  done                 : the tlast word has been popped
//  state                : FSM state (ST_* encoding from spi_load_pkg) for debug
//
// Handshake: a word moves on s_axis when tvalid && tready on a rising edge;
// tready does not depend on tvalid. A pop happens when rb_ready is high and
// the FIFO holds at least one word; rb_ready while empty only flags underflow.
module spi_read_buffer
    import spi_load_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_W-1:0]       spi_data,
    output logic                    last_o,
    input  logic                    rb_ready,
    output logic                    primed,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        words_popped,
    output logic                    underflow,
    output logic                    done,
    output logic [2:0]              state
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] PREFILL_L = LVL_W'(PREFILL);

    logic              flush;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;
    logic              last_seen;
    logic              last_seen_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [2:0]        state_nxt;

    assign flush = rst | clear;

    sync_fifo_fwft #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .flush (flush),
        .push  (push),
        .wdata ({s_axis_tlast, s_axis_tdata}),
        .pop   (pop),
        .rdata (head),
        .level (level)
    );

    assign spi_data = head[DATA_W-1:0];
    assign last_o   = head[DATA_W];

    assign pop = rb_ready && (level != '0);

    // last_seen closes the input for the one STREAM cycle that follows a
    // tlast accepted in FILL, so a second tlast can never get in.
    assign s_axis_tready = ((level != DEPTH_L) || pop) && state_accepts(state) && !last_seen;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign last_seen_nxt = last_seen | (push & s_axis_tlast);

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Popping the tlast word ends the program from any active state; this also
    // covers short programs whose last word leaves before DRAIN is reached.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (pop && last_o)
                    state_nxt = ST_DONE;
                else if ((level_nxt >= PREFILL_L) || last_seen_nxt)
                    state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (pop && last_o)
                    state_nxt = ST_DONE;
                else if (last_seen_nxt)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && last_o) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state        <= ST_IDLE;
            last_seen    <= 1'b0;
            words_popped <= '0;
            underflow    <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_seen <= last_seen_nxt;
            if (pop) words_popped <= words_popped + 1'b1;
            if (rb_ready && (level == '0)) underflow <= 1'b1;
        end
    end

    assign primed = (state == ST_STREAM) || (state == ST_DRAIN);
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_spi_read_buffer.sv
// Bench for spi_read_buffer: directed scenarios plus a randomized run, all
// checked each cycle against a queue-based model of the buffer.
module tb_spi_read_buffer;
    import spi_load_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;
    localparam int CNT_W   = 16;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] spi_data;
    logic              last_o;
    logic              rb_ready = 1'b0;
    logic              primed;
    logic [4:0]        level;
    logic [CNT_W-1:0]  words_popped;
    logic              underflow;
    logic              done;
    logic [2:0]        state;

    spi_read_buffer #(
        .DATA_W (DATA_W), .DEPTH (DEPTH), .PREFILL (PREFILL), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst), .clear (clear),
        .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast), .s_axis_tready (s_axis_tready),
        .spi_data (spi_data), .last_o (last_o), .rb_ready (rb_ready),
        .primed (primed), .level (level), .words_popped (words_popped),
        .underflow (underflow), .done (done), .state (state)
    );

    // scoreboard: expected contents as {last, data}, plus expected flags
    logic [DATA_W:0]  exp_q[$];
    logic [CNT_W-1:0] popped_m;
    bit filling_m, primed_m, last_acc_m, done_m, underflow_m;
    bit push_seen;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        popped_m    = '0;
        filling_m   = 1'b0;
        primed_m    = 1'b0;
        last_acc_m  = 1'b0;
        done_m      = 1'b0;
        underflow_m = 1'b0;
    endtask

    // driver tasks
    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rb_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, compare outputs at the falling edge, advance the model.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit r, input bit clr);
        logic [DATA_W:0] hd;
        logic [DATA_W:0] w;
        bit pop_e, rdy_e, push_e;
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; rb_ready = r; clear = clr;
        @(negedge clk);
        hd    = (exp_q.size() > 0) ? exp_q[0] : '0;
        pop_e = r && (exp_q.size() > 0);
        rdy_e = !done_m && !last_acc_m && ((exp_q.size() < DEPTH) || pop_e);
        check("level",     64'(level),        64'(exp_q.size()));
        check("spi_data",  64'(spi_data),     64'(hd[DATA_W-1:0]));
        check("last_o",    64'(last_o),       64'(hd[DATA_W]));
        check("tready",    64'(s_axis_tready), 64'(rdy_e));
        check("primed",    64'(primed),       64'(primed_m));
        check("done",      64'(done),         64'(done_m));
        check("popped",    64'(words_popped), 64'(popped_m));
        check("underflow", 64'(underflow),    64'(underflow_m));
        push_e    = v && rdy_e;
        push_seen = push_e;
        if (clr) begin
            model_reset();
        end else begin
            if (r && exp_q.size() == 0) underflow_m = 1'b1;
            if (pop_e) begin
                w = exp_q.pop_front();
                popped_m++;
                if (w[DATA_W]) done_m = 1'b1;
            end
            if (push_e) exp_q.push_back({l, d});
            if (push_e && l) last_acc_m = 1'b1;
            // primed follows the first cycle after filling began in which the
            // buffer reaches PREFILL words or has taken the last word
            if (!primed_m && filling_m && (exp_q.size() >= PREFILL || last_acc_m)) primed_m = 1'b1;
            if (push_e) filling_m = 1'b1;
            if (done_m) primed_m = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int budget;

        // 1: reset
        do_reset();
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_level",  64'(level),         64'd0);
        check("rst_primed", 64'(primed),        64'd0);
        check("rst_data",   64'(spi_data),      64'd0);
        check("rst_done",   64'(done),          64'd0);
        check("rst_state",  64'(state),         64'(ST_IDLE));

        // 2: prime with 0xA0..0xA7
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("pre_primed", 64'(primed), 64'd0);
            cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        check("primed_rise", 64'(primed),   64'd1);
        check("prime_head",  64'(spi_data), 64'hA0);

        // 3: fill to 16, then simultaneous push/pop at full, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0; rb_ready = 1'b0; #1;
        check("full_tready", 64'(s_axis_tready), 64'd0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_level", 64'(level), 64'd16);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 4: three-word program ending in tlast
        do_reset();
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        check("last_state", 64'(state), 64'(ST_STREAM));
        check("last_level", 64'(level), 64'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("last_done",   64'(done),         64'd1);
        check("last_popped", 64'(words_popped), 64'd3);
        check("last_state2", 64'(state),        64'(ST_DONE));

        // 5: underflow on empty
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("uf_flag",   64'(underflow),    64'd1);
        check("uf_level",  64'(level),        64'd0);
        check("uf_popped", 64'(words_popped), 64'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // 6: clear with 5 words buffered in STREAM
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("clr_pre_state", 64'(state), 64'(ST_STREAM));
        cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        check("clr_level",  64'(level),  64'd0);
        check("clr_state",  64'(state),  64'(ST_IDLE));
        check("clr_primed", 64'(primed), 64'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // randomized traffic: source-heavy half then sink-heavy half, then end
        do_reset();
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if (i < 200)
                cycle($urandom_range(0, 3) != 0, d, 1'b0, $urandom_range(0, 3) == 0, 1'b0);
            else
                cycle($urandom_range(0, 1) == 0, d, 1'b0, $urandom_range(0, 3) != 0, 1'b0);
        end
        budget = 0;
        push_seen = 1'b0;
        while (!push_seen && budget < 50) begin
            cycle(1'b1, 32'hC0DE_0000 + 32'(budget), 1'b1, $urandom_range(0, 1) == 1, 1'b0);
            budget++;
        end
        check("rand_tlast_taken", 64'(push_seen), 64'd1);
        budget = 0;
        while (done !== 1'b1 && budget < 60) begin
            cycle(1'b0, '0, 1'b0, $urandom_range(0, 3) != 0, 1'b0);
            budget++;
        end
        check("rand_done", 64'(done), 64'd1);
        cycle(1'b1, 32'h5555, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
